// File: rtl/rr_arb_merge.sv
// N-input arbitrated merge: round-robin or fixed-priority grant held for a whole
// packet, each flit tagged with its source index and queued in a small output FIFO.
module rr_arb_merge #(
  parameter int NUM_IN = 4,
  parameter int WIDTH  = 49,
  parameter int DEPTH  = 2,
  parameter int SRC_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    prio_mode,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [SRC_W-1:0]        out_src,
  output logic [15:0]             grant_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic [SRC_W-1:0] src;
    logic             last;
    logic [WIDTH-1:0] data;
  } flit_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] lock_idx, rr_ptr;
  logic [SRC_W-1:0] rr_w, fix_w, win, sel;
  logic             space, push, pop;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  flit_t            mem [DEPTH];
  flit_t            push_flit, head;
  logic [WIDTH-1:0] ch_data [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
  end

  assign space = (count < CNT_W'(DEPTH));

  // Round-robin search: first requester at or after rr_ptr, wrapping to 0.
  always_comb begin
    logic found;
    int   idx;
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    rr_w  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found && in_valid[SRC_W'(idx)]) begin
        found = 1'b1;
        rr_w  = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    fix_w = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_valid[SRC_W'(i)]) fix_w = SRC_W'(i);
    end
  end

  assign win = prio_mode ? fix_w : rr_w;

  // Grant: only registered state and in_valid feed in_ready, never out_ready.
  always_comb begin
    in_ready = '0;
    sel      = win;
    case (state)
      IDLE: begin
        if (rst_n && space && (|in_valid)) in_ready[win] = 1'b1;
      end
      LOCKED: begin
        sel                = lock_idx;
        in_ready[lock_idx] = space;
      end
      default: ;
    endcase
  end

  assign push = |(in_valid & in_ready);
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (push && !in_last[sel]) state_nxt = LOCKED;
      LOCKED:  if (push &&  in_last[sel]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Arbitration bookkeeping only moves on a fresh grant taken from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_idx  <= '0;
      rr_ptr    <= '0;
      grant_cnt <= '0;
    end else if (state == IDLE && push) begin
      lock_idx <= win;
      rr_ptr   <= (win == SRC_W'(NUM_IN - 1)) ? '0 : win + 1'b1;
      if (grant_cnt != 16'hFFFF) grant_cnt <= grant_cnt + 16'd1;
    end
  end

  assign push_flit.src  = sel;
  assign push_flit.last = in_last[sel];
  assign push_flit.data = ch_data[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is reset because the head entry drives out_* directly and must read 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_flit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_data  = head.data;
  assign out_last  = head.last;
  assign out_src   = head.src;

endmodule

// File: tb/tb_rr_arb_merge.sv
// Directed bench for rr_arb_merge: per-channel source queues drive the inputs,
// and a scoreboard monitor checks every flit leaving the FIFO in order.
module tb_rr_arb_merge;

  localparam int NUM_IN = 4;
  localparam int WIDTH  = 49;
  localparam int DEPTH  = 2;
  localparam int SRC_W  = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    prio_mode;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_last;
  logic [SRC_W-1:0]        out_src;
  logic [15:0]             grant_cnt;

  rr_arb_merge #(
    .NUM_IN(NUM_IN), .WIDTH(WIDTH), .DEPTH(DEPTH), .SRC_W(SRC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .prio_mode(prio_mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src), .grant_cnt(grant_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [WIDTH:0]       src_q [NUM_IN][$];
  logic [SRC_W+WIDTH:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic send(input int ch, input logic [WIDTH-1:0] d, input logic last);
    src_q[ch].push_back({last, d});
  endtask

  task automatic exp_flit(input int src, input logic [WIDTH-1:0] d, input logic last);
    exp_q.push_back({SRC_W'(src), last, d});
  endtask

  task automatic clear_all();
    for (int c = 0; c < NUM_IN; c++) src_q[c].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_all();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    bit idle;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk); #3;
      idle = (exp_q.size() == 0) && !out_valid;
      for (int c = 0; c < NUM_IN; c++) if (src_q[c].size() != 0) idle = 1'b0;
      if (idle) done = 1'b1;
    end
    check({"drain_", name}, 64'(done), 64'd1);
  endtask

  // Source driver: retire flits accepted last edge, then present queue heads.
  initial begin
    logic [NUM_IN-1:0] acc;
    logic [WIDTH:0]    h;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    forever begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      for (int c = 0; c < NUM_IN; c++) begin
        if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        if (src_q[c].size() > 0) begin
          h                        = src_q[c][0];
          in_valid[c]              = 1'b1;
          in_last[c]               = h[WIDTH];
          in_data[c*WIDTH +: WIDTH] = h[WIDTH-1:0];
        end else begin
          in_valid[c] = 1'b0;
          in_last[c]  = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every output transfer must match the next expected flit.
  initial begin
    logic [SRC_W+WIDTH:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL out_flit_unexpected actual=%0h required=none", {out_src, out_last, out_data});
        end else begin
          e = exp_q.pop_front();
          check("out_flit", 64'({out_src, out_last, out_data}), 64'(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n     = 1'b0;
    prio_mode = 1'b0;
    out_ready = 1'b0;

    // Reset state, with a requester present so in_ready gating is visible.
    send(0, 49'h1, 1'b1);
    repeat (2) @(posedge clk); #2;
    check("rst_in_ready",  64'(in_ready),  64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_grant_cnt", 64'(grant_cnt), 64'h0);
    check("rst_out_data",  64'(out_data),  64'h0);
    check("rst_out_src",   64'(out_src),   64'h0);
    check("rst_out_last",  64'(out_last),  64'h0);
    clear_all();
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;

    // Reset mid-packet: ch1 locks, fills the FIFO with 2 of 4 flits, then reset.
    send(1, 49'h110, 1'b0); send(1, 49'h111, 1'b0);
    send(1, 49'h112, 1'b0); send(1, 49'h113, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("lock_full_in_ready", 64'(in_ready),  64'h0);
    check("lock_grant_cnt",     64'(grant_cnt), 64'd1);
    check("lock_out_valid",     64'(out_valid), 64'd1);
    check("lock_out_src",       64'(out_src),   64'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    clear_all();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_grant_cnt", 64'(grant_cnt), 64'h0);
    check("midrst_in_ready",  64'(in_ready),  64'h0);
    @(posedge clk); @(posedge clk); #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(3, 49'h3A, 1'b1); exp_flit(2, 49'h2A, 1'b1);
    send(2, 49'h2A, 1'b1); exp_flit(3, 49'h3A, 1'b1);
    @(posedge clk); @(negedge clk);
    check("post_rst_first_grant", 64'(in_ready), 64'b0100);
    drain("post_rst");
    check("post_rst_grant_cnt", 64'(grant_cnt), 64'd2);

    // Round-robin with all four channels requesting single-flit packets.
    do_reset();
    out_ready = 1'b1;
    send(0, 49'h100, 1'b1); send(0, 49'h101, 1'b1);
    send(1, 49'h110, 1'b1); send(1, 49'h111, 1'b1);
    send(2, 49'h120, 1'b1);
    send(3, 49'h130, 1'b1);
    exp_flit(0, 49'h100, 1'b1); exp_flit(1, 49'h110, 1'b1);
    exp_flit(2, 49'h120, 1'b1); exp_flit(3, 49'h130, 1'b1);
    exp_flit(0, 49'h101, 1'b1); exp_flit(1, 49'h111, 1'b1);
    @(posedge clk); @(negedge clk);
    check("rr_first_grant", 64'(in_ready), 64'b0001);
    drain("rr");
    check("rr_grant_cnt", 64'(grant_cnt), 64'd6);

    // Packet lock: ch2 holds the grant for 3 flits while ch0 waits.
    do_reset();
    out_ready = 1'b1;
    send(2, 49'h1_A5A5_0000_0200, 1'b0);
    send(2, 49'h1_A5A5_0000_0201, 1'b0);
    send(2, 49'h1_A5A5_0000_0202, 1'b1);
    exp_flit(2, 49'h1_A5A5_0000_0200, 1'b0);
    exp_flit(2, 49'h1_A5A5_0000_0201, 1'b0);
    exp_flit(2, 49'h1_A5A5_0000_0202, 1'b1);
    exp_flit(0, 49'h0_5A5A_0000_0001, 1'b1);
    exp_flit(0, 49'h0_5A5A_0000_0002, 1'b1);
    @(posedge clk); #2;
    send(0, 49'h0_5A5A_0000_0001, 1'b1);
    send(0, 49'h0_5A5A_0000_0002, 1'b1);
    @(negedge clk);
    check("lock_ch0_blocked", 64'(in_ready), 64'b0100);
    @(negedge clk);
    check("lock_ch0_blocked2", 64'(in_ready), 64'b0100);
    drain("lock");
    check("lock_pkt_grant_cnt", 64'(grant_cnt), 64'd3);

    // Fixed priority: ch1 beats ch3 for as long as ch1 keeps requesting.
    do_reset();
    out_ready = 1'b1;
    prio_mode = 1'b1;
    send(3, 49'h300, 1'b1);
    send(1, 49'h100, 1'b1); send(1, 49'h101, 1'b1); send(1, 49'h102, 1'b1);
    exp_flit(1, 49'h100, 1'b1); exp_flit(1, 49'h101, 1'b1);
    exp_flit(1, 49'h102, 1'b1); exp_flit(3, 49'h300, 1'b1);
    drain("prio");
    check("prio_grant_cnt", 64'(grant_cnt), 64'd4);
    prio_mode = 1'b0;

    // Backpressure: two flits fill the FIFO, a single pop admits exactly one more.
    do_reset();
    out_ready = 1'b0;
    send(0, 49'h1, 1'b1); send(0, 49'h2, 1'b1); send(0, 49'h3, 1'b1);
    exp_flit(0, 49'h1, 1'b1); exp_flit(0, 49'h2, 1'b1); exp_flit(0, 49'h3, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("bp_full_in_ready", 64'(in_ready),  64'h0);
    check("bp_out_valid",     64'(out_valid), 64'd1);
    check("bp_head_data",     64'(out_data),  64'h1);
    check("bp_grant_cnt",     64'(grant_cnt), 64'd2);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_no_ready_path", 64'(in_ready), 64'h0);
    @(posedge clk); #2;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_resume_in_ready", 64'(in_ready), 64'b0001);
    check("bp_head_after_pop",  64'(out_data), 64'h2);
    @(negedge clk);
    check("bp_refull_in_ready", 64'(in_ready), 64'h0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("bp");

    // Streaming at count=DEPTH-1: push and pop together, pointers wrap repeatedly.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1, 49'h1_0000_0000_0050 + 49'(i), (i == 4));
      exp_flit(1, 49'h1_0000_0000_0050 + 49'(i), (i == 4));
    end
    send(3, 49'h77, 1'b1);
    exp_flit(3, 49'h77, 1'b1);
    repeat (3) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("stream_in_ready",  64'(in_ready),  64'b0010);
      check("stream_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
    end
    drain("stream");
    check("stream_grant_cnt", 64'(grant_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_merge.md
# rr_arb_merge

Clocked N-input arbitrated merge for the SNN NoC router datapath. It is the parametrised successor of the two-input arbiter/merge pair. It accepts packets from NUM_IN valid/ready input channels and grants them fairly with round-robin arbitration, or by fixed priority when selected. A grant is held for the whole multi-flit packet, and the block tags each flit with its source index before writing it into an output FIFO of depth DEPTH.

## Interface
- NUM_IN, 4, number of input channels (2..16)
- WIDTH, 49, flit payload width in bits
- DEPTH, 2, output FIFO depth in flits (power of two, ≥2)
- SRC_W, $clog2(NUM_IN), width of source tag
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins); sampled only when no packet is locked
- in_valid  in  NUM_IN  per-channel flit valid
- in_ready  out  NUM_IN  per-channel accept; one-hot or zero
- in_data  in  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- in_last  in  NUM_IN  flit is last of packet (single-flit packet: last=1)
- out_valid  out  1  FIFO head valid
- out_ready  in  1  downstream accept
- out_data  out  WIDTH  head flit payload
- out_last  out  1  head flit last marker
- out_src  out  SRC_W  input index the head flit came from
- grant_cnt  out  16  packets granted since reset, saturating at 0xFFFF

## Operation
- Input transfer on channel i: in_valid[i] & in_ready[i] at a rising edge. Output transfer: out_valid & out_ready.
- space = (count < DEPTH). in_ready depends only on registered state and in_valid. There is no combinational path from out_ready to in_ready.
- States: IDLE (no lock) and LOCKED (owner = lock_idx).
- IDLE:
  - If space and any in_valid, pick winner w and set in_ready[w] = 1.
  - Round-robin picks the first requester at or after rr_ptr, wrapping at NUM_IN−1 → 0. Fixed priority picks the lowest index.
  - On transfer with in_last=0: go to LOCKED with lock_idx = w.
  - On transfer with in_last=1: stay IDLE.
  - Either way, rr_ptr ← (w+1) mod NUM_IN and grant_cnt increments.
- LOCKED:
  - in_ready[lock_idx] = space. All other in_ready are 0 even if valid.
  - A transfer with in_last=1 returns to IDLE.
  - rr_ptr does not change in LOCKED. grant_cnt does not increment.
- prio_mode changes while LOCKED take effect at the next IDLE arbitration.
- Each accepted flit is written to the FIFO tail as {src, last, data}. The head drives out_*.
- Push and pop in the same cycle: count is unchanged and pointers advance mod DEPTH.
- Full FIFO: all in_ready = 0. Arbitration resumes the cycle after a pop frees space.
- Empty FIFO: out_valid = 0, and out_data/out_last/out_src hold their last values (don't-care).

## Timing
- Reset (rst_n low, asynchronous): state IDLE, rr_ptr 0, count 0, FIFO pointers 0, out_valid 0, out_data 0, out_last 0, out_src 0, grant_cnt 0, in_ready 0.
- Reset asserted mid-packet drops the lock and discards all FIFO contents. After reset deasserts, arbitration restarts at index 0.
- Latency: a flit accepted at edge t appears on out_* after edge t, so it is visible in cycle t+1 when the FIFO was empty.
- Throughput: 1 flit/cycle sustained when out_ready is held high.
- in_ready is combinational from in_valid and registered state. out_* come from registers/FIFO storage only.
- A valid flit that is not granted must be held stable by the source until its in_ready is 1.

## Test plan
- Reset mid-packet: lock ch1 after 2 of 4 flits, pulse rst_n low → out_valid 0, count 0, grant_cnt 0; after release, the first grant goes to the lowest requesting index.
- Round-robin, all 4 inputs valid with single-flit packets, out_ready=1 → grant order 0,1,2,3,0,1; out_src follows the same sequence; grant_cnt = 6 after 6 packets.
- Packet lock: ch2 sends 3 flits (last on the 3rd) while ch0 is continuously valid → out_src = 2,2,2 then 0; in_ready[0] = 0 during ch2's packet.
- Fixed priority: prio_mode=1, ch3 and ch1 valid, single flits, out_ready=1 → ch1 is served repeatedly while valid; ch3 is granted only when ch1 deasserts.
- Backpressure, DEPTH=2: out_ready=0 → exactly 2 flits accepted, then all in_ready = 0. Raise out_ready for 1 cycle → one pop, and one new flit is accepted the following cycle. FIFO order is preserved with data 0x1, 0x2, 0x3.
- Simultaneous push/pop at count=DEPTH−1 → count is unchanged and data order is intact across pointer wrap-around.
